// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART-to-ALU framing block: FSM state codes,
// default widths and the default inter-byte timeout.
package uart_alu_interface_pkg;

    // Default widths and timeout, overridable per instance.
    localparam int NB_DATA_DEF        = 8;
    localparam int NB_OP_DEF          = 6;
    localparam int TIMEOUT_CYCLES_DEF = 1000000;

    // FSM state encodings.
    localparam int          ST_W        = 3;
    localparam logic [2:0]  ST_WAIT_A   = 3'd0;
    localparam logic [2:0]  ST_WAIT_B   = 3'd1;
    localparam logic [2:0]  ST_WAIT_OP  = 3'd2;
    localparam logic [2:0]  ST_COMPUTE  = 3'd3;
    localparam logic [2:0]  ST_WAIT_TX  = 3'd4;

    // The inter-byte timeout only runs once a frame has started and is
    // still waiting for operand B or the opcode.
    function automatic logic is_mid_frame(input logic [ST_W-1:0] st);
        return (st == ST_WAIT_B) || (st == ST_WAIT_OP);
    endfunction

endpackage

// File: rtl/uart_alu_interface_rise_detect.sv
// Rising-edge detector: compares the live input against its registered copy
// so a level held high yields exactly one pulse. The pulse is combinational
// off the register, so an input already high when reset is released is seen
// as an edge on the first active cycle.
module rise_detect (
    input  logic clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_pulse
);

    logic sig_q;

    // Remember last cycle's level; reset clears it.
    always_ff @(posedge clk) begin
        if (i_rst) sig_q <= 1'b0;
        else       sig_q <= i_sig;
    end

    assign o_pulse = i_sig & ~sig_q;

endmodule

// File: rtl/uart_alu_interface.sv
// Collects a three-byte frame (A, B, opcode) from a UART receiver, drives
// the operands to an external combinational ALU, and hands the result byte
// to a UART transmitter. A frame that stalls between bytes is abandoned
// after TIMEOUT_CYCLES idle clocks.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int NB_OP          = NB_OP_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout
);

    // A single-cycle timeout still needs a one-bit counter.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             rx_pulse;
    logic [ST_W-1:0]  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ld_a, ld_b, ld_op, ld_tx, expire;

    rise_detect u_rx_edge (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_sig   (i_rx_done),
        .o_pulse (rx_pulse)
    );

    // Next-state and load decisions. A byte arriving on the expiry cycle is
    // checked first, so it always wins over the timeout. Bytes arriving in
    // COMPUTE or WAIT_TX fall through with no effect.
    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        ld_tx     = 1'b0;
        expire    = 1'b0;
        case (state)
            ST_WAIT_A: begin
                if (rx_pulse) begin
                    ld_a      = 1'b1;
                    state_nxt = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (rx_pulse) begin
                    ld_b      = 1'b1;
                    state_nxt = ST_WAIT_OP;
                end else if (cnt == CNT_MAX) begin
                    expire    = 1'b1;
                    state_nxt = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (rx_pulse) begin
                    ld_op     = 1'b1;
                    state_nxt = ST_COMPUTE;
                end else if (cnt == CNT_MAX) begin
                    expire    = 1'b1;
                    state_nxt = ST_WAIT_A;
                end
            end
            ST_COMPUTE: begin
                // Operands have been stable for a full cycle; sample the ALU.
                ld_tx     = 1'b1;
                state_nxt = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) state_nxt = ST_WAIT_A;
            end
            default: state_nxt = ST_WAIT_A;
        endcase
    end

    // Idle counter: advances only while mid-frame with nothing happening;
    // any byte or state change restarts it from zero.
    always_comb begin
        cnt_nxt = '0;
        if (is_mid_frame(state) && !rx_pulse && (state_nxt == state))
            cnt_nxt = cnt + CNT_W'(1);
    end

    // State, counter and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= ST_WAIT_A;
            cnt        <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            o_tx_start <= ld_tx;
            o_timeout  <= expire;
        end
    end

    // Frame registers: each loads only on its own byte and holds otherwise,
    // including across a timeout abort.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
        end else begin
            if (ld_a)  o_alu_a   <= i_rx_data;
            if (ld_b)  o_alu_b   <= i_rx_data;
            if (ld_op) o_alu_op  <= i_rx_data[NB_OP-1:0];
            if (ld_tx) o_tx_data <= i_alu_result;
        end
    end

    assign o_busy = (state == ST_COMPUTE) || (state == ST_WAIT_TX);

endmodule

// File: doc/uart_alu_interface.md
UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 Parameter NB_DATA, 8: width of UART byte, ALU operands and result.
REQ-002 Parameter NB_OP, 6: ALU opcode width, taken from byte bits [NB_OP-1:0].
REQ-003 Parameter TIMEOUT_CYCLES, 1000000: idle clocks allowed between bytes of one frame.
REQ-004 clk  in  1  single clock; one clock domain.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_rx_data  in  NB_DATA  received byte from UART receiver.
REQ-007 i_rx_done  in  1  receiver done level; a new byte is its rising edge.
REQ-008 i_alu_result  in  NB_DATA  combinational ALU result.
REQ-009 i_tx_done  in  1  transmitter finished-byte pulse.
REQ-010 o_alu_a  out  NB_DATA  operand A register.
REQ-011 o_alu_b  out  NB_DATA  operand B register.
REQ-012 o_alu_op  out  NB_OP  opcode register.
REQ-013 o_tx_data  out  NB_DATA  result byte to transmitter.
REQ-014 o_tx_start  out  1  one-cycle transmit request.
REQ-015 o_busy  out  1  high in COMPUTE and WAIT_TX.
REQ-016 o_timeout  out  1  one-cycle pulse on frame abort.

Function
REQ-017 Byte event: rx_pulse = i_rx_done AND NOT registered i_rx_done; a level held high SHALL yield one event.
REQ-018 FSM states WAIT_A, WAIT_B, WAIT_OP, COMPUTE, WAIT_TX.
REQ-019 WAIT_A: on rx_pulse, o_alu_a <= i_rx_data, go WAIT_B.
REQ-020 WAIT_B: on rx_pulse, o_alu_b <= i_rx_data, go WAIT_OP.
REQ-021 WAIT_OP: on rx_pulse, o_alu_op <= i_rx_data[NB_OP-1:0], upper bits ignored, go COMPUTE.
REQ-022 COMPUTE lasts exactly one cycle; at its end o_tx_data <= i_alu_result, o_tx_start <= 1, go WAIT_TX.
REQ-023 Latency: o_tx_start high exactly 2 cycles after the opcode rx_pulse cycle, for exactly one cycle.
REQ-024 WAIT_TX: on i_tx_done go WAIT_A; i_tx_done in any other state ignored.
REQ-025 rx_pulse in COMPUTE or WAIT_TX SHALL be dropped without register change.
REQ-026 Timeout counter clears on every state change and every rx_pulse; counts only in WAIT_B and WAIT_OP.
REQ-027 Counter reaching TIMEOUT_CYCLES-1 with no rx_pulse: go WAIT_A, pulse o_timeout one cycle; o_alu_a/b/op retain values.
REQ-028 rx_pulse in the same cycle as timeout expiry: byte wins, no timeout.
REQ-029 o_alu_a/b/op change only as stated; held stable through COMPUTE and WAIT_TX.

Reset
REQ-030 i_rst SHALL force WAIT_A, all outputs 0, counter 0, registered i_rx_done 0, from any state incl. mid-frame or WAIT_TX.
REQ-031 i_rx_done high at reset release SHALL produce a byte event on the first active cycle.

Structure
REQ-032 Shared package holds state encodings, NB_DATA/NB_OP defaults, TIMEOUT_CYCLES default.
REQ-033 Sub-module rise_detect (registered rising-edge pulse, sync active-high reset) generates rx_pulse.
REQ-034 Counter width = clog2(TIMEOUT_CYCLES).

Verification
REQ-035 Bytes 0x05, 0x03, 0x20 via i_rx_done edges, model ALU ADD -> o_alu_op=0x20, o_tx_data=0x08, o_tx_start one cycle, 2 cycles after third edge.
REQ-036 i_rx_done held high 50 cycles after A=0x11 -> only o_alu_a=0x11 captured, state WAIT_B.
REQ-037 TIMEOUT_CYCLES=16, A=0xAA only -> o_timeout pulse 16 cycles after entering WAIT_B, o_alu_a stays 0xAA, next byte loads o_alu_a.
REQ-038 Extra byte 0x77 during WAIT_TX -> dropped; after i_tx_done next frame 0x01,0x02,op loads A=0x01.
REQ-039 i_rst mid WAIT_OP and mid WAIT_TX -> all outputs 0 next cycle, o_tx_start never asserts.
REQ-040 Byte edge coinciding with timeout expiry cycle -> byte captured, o_timeout stays 0.
